scrambler_link_sequencer: RTL
=============================

Name: scrambler_link_sequencer

Overview:
Frame-level controller that drives the 30-bit parallel scrambler datapath. It generates the scrambler's data word, scramble-enable and seed-reset each cycle: a seed/reseed cycle, then unscrambled training frames, then scrambled VeloPix packets or idle words, with periodic unscrambled sync frames. It sits between the packet source (valid/ready) and the triplicated scrambler top, one instance per link.

Parameters:
TRAIN_FRAMES, 16, number of unscrambled training frames after each (re)seed; legal range >=1
SYNC_PERIOD, 64, RUN slot period; slot 0 of each period carries the sync word; legal range >=2
TRAIN_WORD, 30'h2AAAAAAA, training frame content
SYNC_WORD, 30'h3C0F0F0F, sync frame content
IDLE_WORD, 30'h00000000, content sent scrambled when no packet is available

Ports:
clk  in  1  rising-edge clock; outputs are registered so they are stable at the scrambler's falling-edge capture
rst_n  in  1  reset, asynchronous, active-low
in_data  in  30  packet from source
in_valid  in  1  in_data valid
in_ready  out  1  sequencer accepts in_data this cycle
resync  in  1  single-cycle request to reseed and retrain; level ignored after first cycle
out_data  out  30  word to scrambler dataIn
out_scramble_en  out  1  to scrambler scrambleEnable
scr_rst_n  out  1  synchronous seed reset to scrambler, active-low
link_up  out  1  high while in RUN
sync_pulse  out  1  one-cycle pulse coincident with each sync frame on out_data

Behaviour:
- Reset (rst_n=0): out_data=0, out_scramble_en=0, scr_rst_n=0, in_ready=0, link_up=0, sync_pulse=0, train_cnt=0, slot_cnt=0, state=RESEED. Reset asserted mid-operation aborts immediately; any in-flight packet is dropped.
- States: RESEED, TRAIN, RUN. All outputs are registered, and each output cycle is determined by the state and counters of the previous cycle.
- RESEED (exactly 1 cycle): scr_rst_n=0, out_data=0, out_scramble_en=0. Next state is TRAIN with train_cnt=0.
- TRAIN: emits TRAIN_WORD with out_scramble_en=0 and scr_rst_n=1 for exactly TRAIN_FRAMES consecutive cycles, then moves to RUN. in_ready=0 and link_up=0 throughout. slot_cnt is held at 0.
- RUN: slot_cnt is the slot index of the current output cycle. The first RUN output is slot 1. slot_cnt increments by 1 per cycle and wraps from SYNC_PERIOD-1 to 0.
  - Slot 0: out_data=SYNC_WORD, out_scramble_en=0, sync_pulse=1. The scrambler state is held.
  - Slots 1..SYNC_PERIOD-1: out_scramble_en=1. If a transfer occurred in the previous cycle, out_data is the accepted in_data; otherwise out_data=IDLE_WORD.
- Handshake: in_ready=1 iff the next output slot is a data slot, i.e. (state is TRAIN on its last frame) or (state==RUN and slot_cnt != SYNC_PERIOD-1). in_ready is driven from registers only and never depends on in_valid.
  - A transfer is a cycle with in_valid & in_ready; latency from transfer to out_data is 1 cycle.
  - There is no buffering. The source holds its data while in_ready=0, and no packet is lost or duplicated.
- link_up=1 exactly on cycles whose output is a RUN slot.
- resync: sampled in any state. The next cycle is RESEED; in_ready drops in that same next cycle. A transfer in the resync cycle is still output normally in the following cycle? No: RESEED has priority, so that packet is dropped. Because the source sees in_ready=1 in the resync cycle, a flush is implied, and the source must treat resync as a flush. resync arriving during RESEED or TRAIN restarts RESEED.
- Counter widths: $clog2(TRAIN_FRAMES+1) and $clog2(SYNC_PERIOD). Wrap must be correct for non-power-of-2 SYNC_PERIOD.

Decomposition:
- Package scrambler_ctrl_pkg holds:
  - the state enum (RESEED, TRAIN, RUN);
  - default TRAIN_WORD, SYNC_WORD and IDLE_WORD constants;
  - the width constant DATA_W=30.
- One sub-module is natural: mod_counter (parameter MOD; inputs clear and enable; outputs count and last). It is used for both train_cnt and slot_cnt.

Test Plan:
1. TRAIN_FRAMES=4, SYNC_PERIOD=8, release rst_n -> cycle 1: scr_rst_n=0, out_data=0; cycles 2-5: out_data=2AAAAAAA with en=0; cycle 6: first RUN slot 1, link_up=1.
2. In RUN with in_valid held high and in_data incrementing from 1 -> out_data=1..7 scrambled across slots 1-7; slot 0 carries 3C0F0F0F with en=0 and sync_pulse=1; in_ready=0 exactly on the cycle before each sync slot; no value skipped or repeated.
3. in_valid=0 in RUN -> out_data=00000000 with en=1 on every data slot; sync still at every 8th output.
4. SYNC_PERIOD=5 (non-power-of-2) -> sync_pulse occurs every 5 cycles and slot_cnt wraps 4->0.
5. resync pulse mid-RUN with in_valid=1 -> next cycle RESEED (scr_rst_n=0, in_ready=0, link_up=0); then 4 training frames; then RUN resumes at slot 1.
6. rst_n asserted mid-TRAIN and mid-RUN -> all outputs reach reset values asynchronously, and the full RESEED/TRAIN sequence repeats after release.

Source files
------------

// File: rtl/scrambler_ctrl_pkg.sv
// rtl/scrambler_ctrl_pkg.sv - shared types and constants for the scrambler link sequencer
package scrambler_ctrl_pkg;

  localparam int DATA_W = 30;

  localparam logic [DATA_W-1:0] DEF_TRAIN_WORD = 30'h2AAAAAAA;
  localparam logic [DATA_W-1:0] DEF_SYNC_WORD  = 30'h3C0F0F0F;
  localparam logic [DATA_W-1:0] DEF_IDLE_WORD  = 30'h00000000;

  typedef enum logic [1:0] {
    RESEED = 2'd0,
    TRAIN  = 2'd1,
    RUN    = 2'd2
  } link_state_e;

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-MOD counter with synchronous clear and terminal-count flag
module mod_counter #(
  parameter int MOD = 4,
  parameter int W   = $clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         last
);

  logic [W-1:0] r_count;

  assign count = r_count;
  assign last  = (r_count == W'(MOD - 1));

  // Wrap is an explicit compare so non-power-of-2 moduli roll over correctly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= last ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/scrambler_link_sequencer.sv
// rtl/scrambler_link_sequencer.sv - reseed/train/run frame sequencer feeding one scrambler link
module scrambler_link_sequencer
  import scrambler_ctrl_pkg::*;
#(
  parameter int                TRAIN_FRAMES = 16,
  parameter int                SYNC_PERIOD  = 64,
  parameter logic [DATA_W-1:0] TRAIN_WORD   = DEF_TRAIN_WORD,
  parameter logic [DATA_W-1:0] SYNC_WORD    = DEF_SYNC_WORD,
  parameter logic [DATA_W-1:0] IDLE_WORD    = DEF_IDLE_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              resync,
  output logic [DATA_W-1:0] out_data,
  output logic              out_scramble_en,
  output logic              scr_rst_n,
  output logic              link_up,
  output logic              sync_pulse
);

  localparam int TCW = $clog2(TRAIN_FRAMES + 1);
  localparam int SCW = $clog2(SYNC_PERIOD);

  link_state_e       r_state;
  link_state_e       w_next_state;
  logic              r_resync_d;
  logic              w_resync;
  logic              w_xfer;
  logic [TCW-1:0]    w_train_cnt;
  logic              w_train_last;
  logic [SCW-1:0]    w_slot_cnt;
  logic              w_slot_last;

  logic [DATA_W-1:0] r_out_data,  w_out_data;
  logic              r_out_en,    w_out_en;
  logic              r_scr_rst_n, w_scr_rst_n;
  logic              r_in_ready,  w_in_ready;
  logic              r_link_up,   w_link_up;
  logic              r_sync,      w_sync;

  assign w_resync = resync & ~r_resync_d;
  assign w_xfer   = in_valid & r_in_ready;

  mod_counter #(.MOD(TRAIN_FRAMES), .W(TCW)) u_train_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_resync | (r_state != TRAIN) | w_train_last),
    .enable (1'b1),
    .count  (w_train_cnt),
    .last   (w_train_last)
  );

  // Slot counter steps 0->1 on the last training frame so the first RUN output is slot 1
  mod_counter #(.MOD(SYNC_PERIOD), .W(SCW)) u_slot_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_resync | (r_state == RESEED) | ((r_state == TRAIN) & ~w_train_last)),
    .enable (1'b1),
    .count  (w_slot_cnt),
    .last   (w_slot_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RESEED;
      r_resync_d <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_resync_d <= resync;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RESEED:  w_next_state = TRAIN;
      TRAIN:   if (w_train_last) w_next_state = RUN;
      RUN:     w_next_state = RUN;
      default: w_next_state = RESEED;
    endcase
    if (w_resync) w_next_state = RESEED;
  end

  // Computes the next cycle's outputs; in_ready looks one further slot ahead
  always_comb begin
    w_out_data  = '0;
    w_out_en    = 1'b0;
    w_scr_rst_n = 1'b1;
    w_in_ready  = 1'b0;
    w_link_up   = 1'b0;
    w_sync      = 1'b0;
    case (w_next_state)
      RESEED: w_scr_rst_n = 1'b0;
      TRAIN: begin
        w_out_data = TRAIN_WORD;
        w_in_ready = (r_state == TRAIN) ? (int'(w_train_cnt) + 2 == TRAIN_FRAMES)
                                        : (TRAIN_FRAMES == 1);
      end
      RUN: begin
        w_link_up  = 1'b1;
        w_in_ready = (r_state == RUN) ? (int'(w_slot_cnt) + 2 != SYNC_PERIOD)
                                      : (SYNC_PERIOD != 2);
        if ((r_state == RUN) && w_slot_last) begin
          w_out_data = SYNC_WORD;
          w_sync     = 1'b1;
        end else begin
          w_out_en   = 1'b1;
          w_out_data = w_xfer ? in_data : IDLE_WORD;
        end
      end
      default: w_scr_rst_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_en    <= 1'b0;
      r_scr_rst_n <= 1'b0;
      r_in_ready  <= 1'b0;
      r_link_up   <= 1'b0;
      r_sync      <= 1'b0;
    end else begin
      r_out_data  <= w_out_data;
      r_out_en    <= w_out_en;
      r_scr_rst_n <= w_scr_rst_n;
      r_in_ready  <= w_in_ready;
      r_link_up   <= w_link_up;
      r_sync      <= w_sync;
    end
  end

  assign out_data        = r_out_data;
  assign out_scramble_en = r_out_en;
  assign scr_rst_n       = r_scr_rst_n;
  assign in_ready        = r_in_ready;
  assign link_up         = r_link_up;
  assign sync_pulse      = r_sync;

endmodule
